cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller between the LS1u CPU data port and `bus_unit`. It serves read hits from an on-chip SSRAM data array. It issues line refills, uncached single reads and write-throughs to `bus_unit`, and writes returned refill bytes into the array using `bus_unit`'s `addr_count`/`line_write` stream.

## Interface
- BUS_WIDTH, 8, data width.
- BUS_ADDR, 24, physical address width.
- LINE_BYTES, 128, bytes per line; must equal `bus_unit` MAX_BURST.
- LINES, 8, number of lines (array = LINES*LINE_BYTES bytes).
- Derived: OFS = clog2(LINE_BYTES)=7, IDX = clog2(LINES)=3, TAG = BUS_ADDR-OFS-IDX = 14.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  access request; held until `cpu_ready` or `cpu_fault`.
- cpu_we  in  1  1 = write.
- cpu_addr  in  BUS_ADDR  byte address; bit BUS_ADDR-1 set = uncached region.
- cpu_wdata  in  BUS_WIDTH  write data.
- cpu_rdata  out  BUS_WIDTH  read data, valid with `cpu_ready`.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_fault  out  1  one-cycle bus-error pulse.
- flush  in  1  invalidate all lines; sampled in IDLE only.
- read_line_req, read_req, write_through_req  out  1 each  requests to `bus_unit`; at most one high.
- pa  out  BUS_ADDR  request address, stable while any request is high.
- wt_data  out  BUS_WIDTH  write-through data, stable with request.
- line_data  in  BUS_WIDTH  refill/single-read data.
- addr_count  in  OFS  refill byte offset.
- line_write  in  1  refill byte strobe.
- cache_entry_refill  in  1  line complete.
- trans_rdy  in  1  transfer complete.
- bus_error  in  1  access fault.

## Operation
- Storage: data array LINES*LINE_BYTES bytes, 1-cycle synchronous read; tag regs TAG bits/line; valid flops 1 bit/line.
- States: IDLE, LOOKUP, REFILL, UNC_RD, WRITE.
- IDLE: if `flush`, clear all valids in one cycle, stay in IDLE; `flush` takes priority over `cpu_req`. Otherwise on `cpu_req`, register the address, data and `we`, present the array read address, and go to LOOKUP.
- LOOKUP:
  - hit = valid[idx] & tag match & !uncached.
  - Read hit: `cpu_ready`=1 with array data, then IDLE.
  - Read miss, cached: REFILL.
  - Read, uncached: UNC_RD.
  - Write (any): WRITE.
- REFILL: `read_line_req`=1, `pa` = {tag, idx, OFS'b0}.
  - Each `line_write`: array[idx*LINE_BYTES+addr_count] <= line_data.
  - valid[idx] cleared on entry.
  - `cache_entry_refill`: tag[idx] <= tag, valid[idx] <= 1, re-present the array read address, go to LOOKUP (replay); the replay hits.
- UNC_RD: `read_req`=1, `pa`=address. On `trans_rdy`: `cpu_rdata`=line_data, `cpu_ready`, IDLE. Nothing is cached.
- WRITE: `write_through_req`=1, `pa`=address, `wt_data`=data. On `trans_rdy`: `cpu_ready`; if hit, array byte also written that cycle; IDLE. A write miss does not allocate.
- `bus_error` in any bus state: drop the request, pulse `cpu_fault`, go to IDLE. In REFILL, valid[idx] stays 0.
- `bus_error` and `trans_rdy` in the same cycle: error wins.
- `rst` mid-transfer: state IDLE, all valids 0, requests drop the same cycle; tags and data not cleared.

## Timing
- Reset values: all outputs 0; `pa`, `wt_data`, `cpu_rdata` = 0.
- Read hit: accept edge T0, `cpu_ready` in cycle T1; 2-cycle latency, 1 access per 2 cycles.
- Refill: LOOKUP → REFILL → (bus) → LOOKUP; `cpu_ready` 1 cycle after `cache_entry_refill`.
- Write/uncached: `cpu_ready` coincides with `trans_rdy`.
- Requests are level signals, asserted from the first cycle of a bus state until the completion/error cycle inclusive.
- `line_write` is honoured only in REFILL; `line_write` outside REFILL is ignored.

## Structure
- Package `cache_pkg`: state enum, OFS/IDX/TAG width functions, uncached-region bit constant.
- Sub-module `cache_data_ram`: single-port byte SSRAM, sync read and write, M9K-inferable. Port arbitration: REFILL write > WRITE-hit write > lookup read.
- Tags and valids live in flops inside `cache_ctrl`.

## Test plan
- Cold read 0x000105 → `read_line_req` with `pa`=0x000100; bus model returns bytes 0x00..0x7F at offsets 0..127 → `cpu_ready` with rdata 0x05; the next read of 0x000110 hits, rdata 0x10, `cpu_ready` 1 cycle after accept, no bus request.
- Write 0xA5 to 0x000110 (hit) → `write_through_req`, `pa`=0x000110, `wt_data`=0xA5; after `trans_rdy`, read of 0x000110 hits with 0xA5.
- Write to 0x004000 (miss) → write-through only; following read of 0x004000 issues `read_line_req` (no allocate).
- Read of 0x800010 twice → two `read_req`, never `read_line_req`; rdata = bus byte each time.
- `bus_error` during refill of line 2 → `cpu_fault` pulse, `read_line_req` low next cycle, re-read misses again.
- `flush` in IDLE after the lines are filled → every next access misses; assert `rst` mid-REFILL → requests low next cycle, all lines invalid.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared FSM encoding and address-geometry helpers for the direct-mapped
// write-through data cache.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_UNC_RD,
        S_WRITE
    } state_t;

    function automatic int ofs_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int bus_addr, input int line_bytes, input int lines);
        return bus_addr - $clog2(line_bytes) - $clog2(lines);
    endfunction

    // The uncached region is selected by the address MSB.
    localparam int UNC_FROM_MSB = 1;

endpackage

// File: rtl/cache_data_ram.sv
// Single-port byte-wide SSRAM with registered read; read-during-write returns
// the old contents, which keeps it inferable as a block RAM.
module cache_data_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller sitting
// between the CPU data port and bus_unit.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int BUS_ADDR   = 24,
    parameter int LINE_BYTES = 128,
    parameter int LINES      = 8,
    localparam int OFS = ofs_bits(LINE_BYTES),
    localparam int IDX = idx_bits(LINES),
    localparam int TAG = tag_bits(BUS_ADDR, LINE_BYTES, LINES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [BUS_ADDR-1:0]  cpu_addr,
    input  logic [BUS_WIDTH-1:0] cpu_wdata,
    output logic [BUS_WIDTH-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 cpu_fault,
    input  logic                 flush,
    output logic                 read_line_req,
    output logic                 read_req,
    output logic                 write_through_req,
    output logic [BUS_ADDR-1:0]  pa,
    output logic [BUS_WIDTH-1:0] wt_data,
    input  logic [BUS_WIDTH-1:0] line_data,
    input  logic [OFS-1:0]       addr_count,
    input  logic                 line_write,
    input  logic                 cache_entry_refill,
    input  logic                 trans_rdy,
    input  logic                 bus_error
);

    localparam int UNC = BUS_ADDR - UNC_FROM_MSB;
    localparam int RAW = OFS + IDX;

    state_t                state, state_nxt;
    logic [BUS_ADDR-1:0]   addr_r;
    logic [BUS_WIDTH-1:0]  data_r;
    logic                  we_r;
    logic [LINES-1:0]      valid;
    logic [TAG-1:0]        tags [LINES];

    logic [TAG-1:0]        tag_a;
    logic [IDX-1:0]        idx_a;
    logic [OFS-1:0]        ofs_a;
    logic                  hit;

    logic                  accept, do_flush, refill_start, refill_done;
    logic                  ram_we;
    logic [RAW-1:0]        ram_addr;
    logic [BUS_WIDTH-1:0]  ram_wdata, ram_rdata;

    assign tag_a = addr_r[BUS_ADDR-1 -: TAG];
    assign idx_a = addr_r[RAW-1 -: IDX];
    assign ofs_a = addr_r[OFS-1:0];
    assign hit   = valid[idx_a] && (tags[idx_a] == tag_a) && !addr_r[UNC];

    cache_data_ram #(
        .WIDTH (BUS_WIDTH),
        .AW    (RAW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || do_flush)  valid        <= '0;
        else if (refill_start) valid[idx_a] <= 1'b0;
        else if (refill_done)  valid[idx_a] <= 1'b1;
    end

    // Tags and the captured request are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_r <= cpu_addr;
            data_r <= cpu_wdata;
            we_r   <= cpu_we;
        end
        if (refill_done) tags[idx_a] <= tag_a;
    end

    always_comb begin
        state_nxt         = state;
        cpu_rdata         = '0;
        cpu_ready         = 1'b0;
        cpu_fault         = 1'b0;
        read_line_req     = 1'b0;
        read_req          = 1'b0;
        write_through_req = 1'b0;
        pa                = '0;
        wt_data           = '0;
        accept            = 1'b0;
        do_flush          = 1'b0;
        refill_start      = 1'b0;
        refill_done       = 1'b0;
        ram_we            = 1'b0;
        ram_addr          = {idx_a, ofs_a};
        ram_wdata         = data_r;

        case (state)
            S_IDLE: begin
                if (flush) begin
                    do_flush = 1'b1;
                end else if (cpu_req) begin
                    accept    = 1'b1;
                    ram_addr  = cpu_addr[RAW-1:0];
                    state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (we_r) begin
                    state_nxt = S_WRITE;
                end else if (addr_r[UNC]) begin
                    state_nxt = S_UNC_RD;
                end else if (hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = ram_rdata;
                    state_nxt = S_IDLE;
                end else begin
                    refill_start = 1'b1;
                    state_nxt    = S_REFILL;
                end
            end
            S_REFILL: begin
                read_line_req = 1'b1;
                pa            = {tag_a, idx_a, {OFS{1'b0}}};
                // Refill bytes own the RAM port; the replay read below relies on
                // cache_entry_refill arriving after the last line_write.
                if (line_write) begin
                    ram_we    = 1'b1;
                    ram_addr  = {idx_a, addr_count};
                    ram_wdata = line_data;
                end
                if (bus_error) begin
                    cpu_fault = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cache_entry_refill) begin
                    refill_done = 1'b1;
                    state_nxt   = S_LOOKUP;
                end
            end
            S_UNC_RD: begin
                read_req = 1'b1;
                pa       = addr_r;
                if (bus_error) begin
                    cpu_fault = 1'b1;
                    state_nxt = S_IDLE;
                end else if (trans_rdy) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = line_data;
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                write_through_req = 1'b1;
                pa                = addr_r;
                wt_data           = data_r;
                if (bus_error) begin
                    cpu_fault = 1'b1;
                    state_nxt = S_IDLE;
                end else if (trans_rdy) begin
                    cpu_ready = 1'b1;
                    ram_we    = hit;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Reset silences the bus side immediately, not one edge later.
        if (rst) begin
            cpu_rdata         = '0;
            cpu_ready         = 1'b0;
            cpu_fault         = 1'b0;
            read_line_req     = 1'b0;
            read_req          = 1'b0;
            write_through_req = 1'b0;
            pa                = '0;
            wt_data           = '0;
            accept            = 1'b0;
            do_flush          = 1'b0;
            refill_start      = 1'b0;
            refill_done       = 1'b0;
            ram_we            = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboarded bench for cache_ctrl: the bench doubles as bus_unit, backed by
// a byte memory model that supplies refill, single-read and write-through data.
module tb_cache_ctrl;

    logic        clk, rst;
    logic        cpu_req, cpu_we;
    logic [23:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ready, cpu_fault, flush;
    logic        read_line_req, read_req, write_through_req;
    logic [23:0] pa;
    logic [7:0]  wt_data, line_data;
    logic [6:0]  addr_count;
    logic        line_write, cache_entry_refill, trans_rdy, bus_error;

    cache_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_req            (cpu_req),
        .cpu_we             (cpu_we),
        .cpu_addr           (cpu_addr),
        .cpu_wdata          (cpu_wdata),
        .cpu_rdata          (cpu_rdata),
        .cpu_ready          (cpu_ready),
        .cpu_fault          (cpu_fault),
        .flush              (flush),
        .read_line_req      (read_line_req),
        .read_req           (read_req),
        .write_through_req  (write_through_req),
        .pa                 (pa),
        .wt_data            (wt_data),
        .line_data          (line_data),
        .addr_count         (addr_count),
        .line_write         (line_write),
        .cache_entry_refill (cache_entry_refill),
        .trans_rdy          (trans_rdy),
        .bus_error          (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];
    logic [7:0] bmem [logic [23:0]];

    int cycles, n_line, n_rd, n_wt, refill_cyc, ready_cyc;
    bit faulted;

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a[7:0] ^ {a[15:12], a[23:20]};
    endfunction

    task automatic bus_clear();
        line_write         = 1'b0;
        cache_entry_refill = 1'b0;
        trans_rdy          = 1'b0;
        bus_error          = 1'b0;
        addr_count         = '0;
        line_data          = '0;
        flush              = 1'b0;
    endtask

    // One CPU access; the bench answers bus requests until ready/fault.
    task automatic access(input string name, input logic we, input logic [23:0] a,
                          input logic [7:0] d, input bit err);
        int rc, wc;
        bit done;
        logic [7:0] e;
        @(negedge clk);
        bus_clear();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        if (!we && !err) exp_q.push_back(mem_rd(a));
        cycles = 0; n_line = 0; n_rd = 0; n_wt = 0; faulted = 0;
        refill_cyc = -1; ready_cyc = -1;
        rc = 0; wc = 0; done = 0;
        while (!done && cycles < 400) begin
            @(negedge clk);
            cycles++;
            bus_clear();
            checks++;
            if (int'(read_line_req) + int'(read_req) + int'(write_through_req) > 1) begin
                errors++;
                $display("FAIL %s one_req: got %b%b%b want at most one", name,
                         read_line_req, read_req, write_through_req);
            end
            if (read_line_req) begin
                if (rc == 0) begin
                    n_line++;
                    checks++;
                    if (pa !== {a[23:7], 7'h00}) begin
                        errors++;
                        $display("FAIL %s line_pa: got %h want %h", name, pa, {a[23:7], 7'h00});
                    end
                end
                if (err && rc == 40) begin
                    bus_error = 1'b1;
                end else if (rc < 128) begin
                    line_write = 1'b1;
                    addr_count = rc[6:0];
                    line_data  = mem_rd({a[23:7], rc[6:0]});
                end else begin
                    cache_entry_refill = 1'b1;
                    refill_cyc         = cycles;
                end
                rc++;
            end else begin
                rc = 0;
            end
            if (read_req || write_through_req) begin
                if (wc == 0) begin
                    checks++;
                    if (pa !== a) begin
                        errors++;
                        $display("FAIL %s pa: got %h want %h", name, pa, a);
                    end
                    if (read_req) n_rd++;
                    else begin
                        n_wt++;
                        checks++;
                        if (wt_data !== d) begin
                            errors++;
                            $display("FAIL %s wt_data: got %h want %h", name, wt_data, d);
                        end
                    end
                end
                if (wc == 2) begin
                    trans_rdy = 1'b1;
                    if (read_req) line_data = mem_rd(a);
                    else          bmem[a] = d;
                end
                wc++;
            end else begin
                wc = 0;
            end
            #1;
            if (cpu_fault) begin
                done = 1; faulted = 1;
            end else if (cpu_ready) begin
                done = 1; ready_cyc = cycles;
                if (!we) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s rdata: got %h want no read pending", name, cpu_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (cpu_rdata !== e) begin
                            errors++;
                            $display("FAIL %s rdata: got %h want %h", name, cpu_rdata, e);
                        end
                    end
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: got no completion want ready/fault", name);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        bus_clear();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({cpu_ready, cpu_fault, read_line_req, read_req, write_through_req} !== 5'b0 ||
            pa !== 24'h0 || wt_data !== 8'h0 || cpu_rdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_outs: got rdy%b flt%b req%b%b%b pa%h wt%h rd%h want all 0",
                     cpu_ready, cpu_fault, read_line_req, read_req, write_through_req,
                     pa, wt_data, cpu_rdata);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({cpu_ready, cpu_fault, read_line_req, read_req, write_through_req} !== 5'b0) begin
            errors++;
            $display("FAIL idle_outs: got %b want 00000",
                     {cpu_ready, cpu_fault, read_line_req, read_req, write_through_req});
        end
    endtask

    task automatic test_cold_refill();
        access("cold_rd", 1'b0, 24'h000105, 8'h00, 1'b0);
        chk("cold_line_reqs", n_line, 1);
        chk("cold_ready_gap", ready_cyc, refill_cyc + 1);
    endtask

    task automatic test_back_to_back();
        logic [23:0] addrs [4];
        addrs = '{24'h000110, 24'h000111, 24'h00017F, 24'h000100};
        foreach (addrs[i]) begin
            access("hit_rd", 1'b0, addrs[i], 8'h00, 1'b0);
            chk("hit_latency", cycles, 1);
            chk("hit_bus_reqs", n_line + n_rd + n_wt, 0);
        end
    endtask

    task automatic test_write_hit();
        access("wr_hit", 1'b1, 24'h000110, 8'hA5, 1'b0);
        chk("wr_hit_wt", n_wt, 1);
        access("wr_hit_rd", 1'b0, 24'h000110, 8'h00, 1'b0);
        chk("wr_hit_rd_lat", cycles, 1);
        chk("wr_hit_rd_line", n_line, 0);
    endtask

    task automatic test_write_miss();
        access("wr_miss", 1'b1, 24'h004000, 8'h3C, 1'b0);
        chk("wr_miss_wt", n_wt, 1);
        chk("wr_miss_line", n_line, 0);
        access("wr_miss_rd", 1'b0, 24'h004000, 8'h00, 1'b0);
        chk("wr_miss_rd_line", n_line, 1);
    endtask

    task automatic test_uncached();
        repeat (2) begin
            access("unc_rd", 1'b0, 24'h800010, 8'h00, 1'b0);
            chk("unc_rd_reqs", n_rd, 1);
            chk("unc_line_reqs", n_line, 0);
        end
    endtask

    task automatic test_bus_error();
        access("err_refill", 1'b0, 24'h000500, 8'h00, 1'b1);
        chk("err_fault", int'(faulted), 1);
        @(negedge clk);
        bus_clear(); cpu_req = 1'b0;
        #1;
        chk("err_req_drop", int'(read_line_req), 0);
        chk("err_fault_pulse", int'(cpu_fault), 0);
        access("err_reread", 1'b0, 24'h000500, 8'h00, 1'b0);
        chk("err_reread_line", n_line, 1);
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus_clear();
        flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000510;
        @(negedge clk);
        flush = 1'b0; cpu_req = 1'b0;
        #1;
        chk("flush_prio_rdy", int'(cpu_ready), 0);
        @(negedge clk); #1;
        chk("flush_prio_req", int'(read_line_req), 0);
        access("flush_rd2", 1'b0, 24'h000510, 8'h00, 1'b0);
        chk("flush_rd2_line", n_line, 1);
        access("flush_rd0", 1'b0, 24'h004000, 8'h00, 1'b0);
        chk("flush_rd0_line", n_line, 1);
    endtask

    task automatic test_stray_line_write();
        @(negedge clk);
        bus_clear(); cpu_req = 1'b0;
        line_write = 1'b1; addr_count = 7'h00; line_data = 8'hEE;
        @(negedge clk);
        bus_clear();
        access("stray_rd", 1'b0, 24'h004000, 8'h00, 1'b0);
        chk("stray_rd_line", n_line, 0);
    endtask

    task automatic test_rst_refill();
        int n;
        @(negedge clk);
        bus_clear();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000200;
        n = 0;
        do begin @(negedge clk); n++; end while (!read_line_req && n < 10);
        chk("rst_refill_start", int'(read_line_req), 1);
        for (int i = 0; i < 4; i++) begin
            line_write = 1'b1; addr_count = i[6:0]; line_data = 8'h55;
            @(negedge clk);
        end
        bus_clear();
        rst = 1'b1; cpu_req = 1'b0;
        #1;
        chk("rst_req_same", int'(read_line_req), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_next", int'(read_line_req | read_req | write_through_req | cpu_ready), 0);
        access("rst_rd0", 1'b0, 24'h004000, 8'h00, 1'b0);
        chk("rst_rd0_line", n_line, 1);
        access("rst_rd2", 1'b0, 24'h000510, 8'h00, 1'b0);
        chk("rst_rd2_line", n_line, 1);
    endtask

    initial begin
        test_reset();
        test_cold_refill();
        test_back_to_back();
        test_write_hit();
        test_write_miss();
        test_uncached();
        test_bus_error();
        test_flush();
        test_stray_line_write();
        test_rst_refill();
        @(negedge clk);
        bus_clear(); cpu_req = 1'b0;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
